// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared types and constants for the VGA draw/capture chain.
//                The capture FSM state encoding, the flattened video bundle
//                used by delay lines, and the packed-address field width.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_pkg;

    // Width of one sub-field of the {row,col} packed image-RAM address
    localparam int ADDR_SUB_W = 6;

    // Largest capture width or height the packed address can hold
    localparam int MAX_DIM = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2
    } cap_state_t;

    // Field order matches the vga_if signal list
    typedef struct packed {
        logic [11:0] hcount;
        logic [11:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_sig_t;

endpackage
`default_nettype wire

// File: rtl/vga_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_if
//  Description : Video timing plus pixel colour bundle passed between the
//                blocks of the draw chain.
//  Revision    : 1.0  initial release
// ============================================================================
interface vga_if;
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface
`default_nettype wire

// File: rtl/vga_delay.sv
`default_nettype none
// ============================================================================
//  Module      : vga_delay
//  Description : Registered pass-through of a vga_if bundle, DEPTH clocks
//                deep. All fields travel together so timing stays aligned.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_delay
    import vga_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    vga_if.in    vga_in,
    vga_if.out   vga_out
);

    vga_sig_t w_in;
    vga_sig_t r_pipe [DEPTH];

    assign w_in = {vga_in.hcount, vga_in.vcount, vga_in.hsync, vga_in.vsync,
                   vga_in.hblnk, vga_in.vblnk, vga_in.rgb};

    // Shift the whole bundle one stage per clock; reset clears every stage
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_in;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign vga_out.hcount = r_pipe[DEPTH-1].hcount;
    assign vga_out.vcount = r_pipe[DEPTH-1].vcount;
    assign vga_out.hsync  = r_pipe[DEPTH-1].hsync;
    assign vga_out.vsync  = r_pipe[DEPTH-1].vsync;
    assign vga_out.hblnk  = r_pipe[DEPTH-1].hblnk;
    assign vga_out.vblnk  = r_pipe[DEPTH-1].vblnk;
    assign vga_out.rgb    = r_pipe[DEPTH-1].rgb;

endmodule
`default_nettype wire

// File: rtl/capture_rect.sv
`default_nettype none
// ============================================================================
//  Module      : capture_rect
//  Description : Grabs one W x H rectangle of the live pixel stream, starting
//                at (x,y) of the next full frame, into an image RAM addressed
//                {row[5:0],col[5:0]}. Video passes through 1 clock delayed.
//  Revision    : 1.0  initial release
// ============================================================================
module capture_rect
    import vga_pkg::*;
#(
    parameter int W = 50,
    parameter int H = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] x,
    input  logic [11:0] y,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        partial,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [11:0] wr_data,
    vga_if.in           vga_in,
    vga_if.out          vga_out
);

    // Counter wide enough to hold MAX_DIM*MAX_DIM without wrapping
    localparam int               c_CNT_W = $clog2(MAX_DIM * MAX_DIM + 1);
    localparam logic [c_CNT_W-1:0] c_TOTAL = c_CNT_W'(W * H);
    localparam logic [12:0]      c_W13   = 13'(W);
    localparam logic [12:0]      c_H13   = 13'(H);

    cap_state_t              r_state;
    cap_state_t              w_state_nxt;
    logic [11:0]             r_x;
    logic [11:0]             r_y;
    logic [c_CNT_W-1:0]      r_cnt;
    logic                    r_done;
    logic                    r_partial;
    logic                    r_wr_en;
    logic [11:0]             r_wr_addr;
    logic [11:0]             r_wr_data;

    logic                    w_origin;
    logic                    w_in_win;
    logic                    w_full;
    logic                    w_wr;
    logic                    w_done_nxt;
    logic                    w_abort;
    logic [12:0]             w_h13;
    logic [12:0]             w_v13;
    logic [12:0]             w_x13;
    logic [12:0]             w_y13;
    logic [ADDR_SUB_W-1:0]   w_col;
    logic [ADDR_SUB_W-1:0]   w_row;

    vga_delay #(
        .DEPTH (1)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .vga_in  (vga_in),
        .vga_out (vga_out)
    );

    // 13-bit compares keep x+W and y+H from wrapping near the 12-bit limit
    assign w_h13    = {1'b0, vga_in.hcount};
    assign w_v13    = {1'b0, vga_in.vcount};
    assign w_x13    = {1'b0, r_x};
    assign w_y13    = {1'b0, r_y};
    assign w_origin = (vga_in.hcount == 12'd0) && (vga_in.vcount == 12'd0);
    assign w_in_win = (w_h13 >= w_x13) && (w_h13 < w_x13 + c_W13) &&
                      (w_v13 >= w_y13) && (w_v13 < w_y13 + c_H13) &&
                      !vga_in.hblnk && !vga_in.vblnk;
    assign w_full   = (r_cnt == c_TOTAL);
    assign w_col    = ADDR_SUB_W'(vga_in.hcount - r_x);
    assign w_row    = ADDR_SUB_W'(vga_in.vcount - r_y);

    // Capture FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus per-pixel write / completion decisions
    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_done_nxt  = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // The origin pixel itself already belongs to the captured frame
                if (w_origin) begin
                    w_state_nxt = ST_CAPTURE;
                    w_wr        = w_in_win;
                end
            end
            ST_CAPTURE: begin
                if (w_full) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (w_origin) begin
                    // A new frame began before the window was filled
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                    w_abort     = 1'b1;
                end else begin
                    w_wr = w_in_win;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Window latch, pixel counter and registered RAM/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x       <= '0;
            r_y       <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_partial <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_x       <= x;
                r_y       <= y;
                r_cnt     <= '0;
                r_partial <= 1'b0;
            end else if (w_wr) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_wr_en   <= w_wr;
            r_wr_addr <= w_wr ? {w_row, w_col} : 12'd0;
            r_wr_data <= w_wr ? vga_in.rgb : 12'd0;
            r_done    <= w_done_nxt;
            if (w_done_nxt) begin
                r_partial <= w_abort;
            end
        end
    end

    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;
    assign partial = r_partial;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_capture_rect.sv
`default_nettype none
// ============================================================================
//  Module      : tb_capture_rect
//  Description : Directed bench for capture_rect. A W=4,H=2 instance covers
//                the in-frame cases, a W=8,H=2 instance the right-edge case.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_capture_rect;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [11:0] x_a, y_a, x_b, y_b;
    logic        busy_a, done_a, partial_a, wr_en_a;
    logic        busy_b, done_b, partial_b, wr_en_b;
    logic [11:0] wr_addr_a, wr_data_a, wr_addr_b, wr_data_b;

    vga_if vin ();
    vga_if vout_a ();
    vga_if vout_b ();

    capture_rect #(.W(4), .H(2)) dut_a (
        .clk(clk), .rst(rst), .x(x_a), .y(y_a), .start(start_a),
        .busy(busy_a), .done(done_a), .partial(partial_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .vga_in(vin), .vga_out(vout_a)
    );

    capture_rect #(.W(8), .H(2)) dut_b (
        .clk(clk), .rst(rst), .x(x_b), .y(y_b), .start(start_b),
        .busy(busy_b), .done(done_b), .partial(partial_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .vga_in(vin), .vga_out(vout_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // timing generator state (driven only from the stimulus process)
    int hc, vc, h_act, h_tot, v_act, v_tot;

    // monitor results (written only by the monitor)
    logic [23:0] qa[$];
    logic [23:0] qb[$];
    int cyc = 0;
    int last_wr_a = 0, done_cnt_a = 0, done_cyc_a = 0, idle_nz_a = 0;
    int done_cnt_b = 0, done_gap_b = 0, origin_cyc = 0;
    int dly_err = 0, dly_chk = 0;
    logic part_a = 1'b0, part_b = 1'b0;
    logic prev_ok = 1'b0;
    vga_sig_t prev_in, cur_in, cur_oa, cur_ob;

    function automatic logic [11:0] pix(input int h, input int v);
        return 12'((h * 7 + v * 131 + 3) % 4096);
    endfunction

    task automatic drive();
        vin.hcount = 12'(hc);
        vin.vcount = 12'(vc);
        vin.hblnk  = (hc >= h_act);
        vin.vblnk  = (vc >= v_act);
        vin.hsync  = (hc >= h_act + 2) && (hc < h_act + 6);
        vin.vsync  = (vc == v_act + 1);
        vin.rgb    = pix(hc, vc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        hc++;
        if (hc >= h_tot) begin
            hc = 0;
            vc++;
            if (vc >= v_tot) vc = 0;
        end
        drive();
    endtask

    // restart the raster just after a frame origin so the next origin is a full frame away
    task automatic set_timing(input int ha, input int ht, input int va, input int vt);
        h_act = ha; h_tot = ht; v_act = va; v_tot = vt;
        hc = 0; vc = 1;
        drive();
    endtask

    task automatic wait_done(input bit sel_b, input int d0, input int budget, output bit ok);
        int k;
        ok = 1'b0;
        k  = 0;
        while (!ok && k < budget) begin
            step();
            k++;
            if (sel_b ? (done_cnt_b != d0) : (done_cnt_a != d0)) ok = 1'b1;
        end
    endtask

    // sample outputs on the falling edge, away from the active edge
    always @(negedge clk) begin
        cyc++;
        if (wr_en_a) begin
            qa.push_back({wr_addr_a, wr_data_a});
            last_wr_a = cyc;
        end
        if (!wr_en_a && (wr_addr_a != 12'd0 || wr_data_a != 12'd0)) idle_nz_a++;
        if (done_a) begin
            done_cnt_a++;
            done_cyc_a = cyc;
            part_a     = partial_a;
        end
        if (wr_en_b) qb.push_back({wr_addr_b, wr_data_b});
        if (done_b) begin
            done_cnt_b++;
            done_gap_b = cyc - origin_cyc;
            part_b     = partial_b;
        end
        cur_in = {vin.hcount, vin.vcount, vin.hsync, vin.vsync, vin.hblnk, vin.vblnk, vin.rgb};
        cur_oa = {vout_a.hcount, vout_a.vcount, vout_a.hsync, vout_a.vsync,
                  vout_a.hblnk, vout_a.vblnk, vout_a.rgb};
        cur_ob = {vout_b.hcount, vout_b.vcount, vout_b.hsync, vout_b.vsync,
                  vout_b.hblnk, vout_b.vblnk, vout_b.rgb};
        if (prev_ok) begin
            dly_chk++;
            if (cur_oa !== prev_in || cur_ob !== prev_in) dly_err++;
        end
        prev_in = cur_in;
        prev_ok = !rst;
        if (vin.hcount == 12'd0 && vin.vcount == 12'd0) origin_cyc = cyc;
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_cmp++;
        if ({busy_a, done_a, partial_a, wr_en_a, wr_addr_a, wr_data_a} !== 28'd0) begin
            n_bad++;
            $display("FAIL reset_outs_a: got %h expected 0",
                     {busy_a, done_a, partial_a, wr_en_a, wr_addr_a, wr_data_a});
        end
        n_cmp++;
        if ({busy_b, done_b, partial_b, wr_en_b, wr_addr_b, wr_data_b} !== 28'd0) begin
            n_bad++;
            $display("FAIL reset_outs_b: got %h expected 0",
                     {busy_b, done_b, partial_b, wr_en_b, wr_addr_b, wr_data_b});
        end
        n_cmp++;
        if (cur_oa !== 40'd0 || vout_a.rgb !== 12'd0 || vout_a.hcount !== 12'd0) begin
            n_bad++;
            $display("FAIL reset_vga_out_a: got rgb=%h hcount=%h expected 0", vout_a.rgb, vout_a.hcount);
        end
        n_cmp++;
        if (vout_b.rgb !== 12'd0 || vout_b.vcount !== 12'd0 || vout_b.hblnk !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_vga_out_b: got rgb=%h vcount=%h expected 0", vout_b.rgb, vout_b.vcount);
        end
        rst = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_basic(input string tag);
        int n0, d0, i0;
        bit ok;
        logic [23:0] exp;
        set_timing(32, 40, 8, 10);
        n0 = qa.size(); d0 = done_cnt_a; i0 = idle_nz_a;
        x_a = 12'd10; y_a = 12'd5; start_a = 1'b1;
        step();
        start_a = 1'b0;
        n_cmp++;
        if (busy_a !== 1'b1) begin
            n_bad++; $display("FAIL %s busy_after_start: got %b expected 1", tag, busy_a);
        end
        wait_done(1'b0, d0, 1500, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL %s done_timeout: got none expected done", tag); end
        n_cmp++;
        if (qa.size() - n0 != 8) begin
            n_bad++; $display("FAIL %s write_count: got %0d expected 8", tag, qa.size() - n0);
        end
        for (int i = 0; i < 8; i++) begin
            if (n0 + i < qa.size()) begin
                exp = {12'((i / 4) * 64 + (i % 4)), pix(10 + i % 4, 5 + i / 4)};
                n_cmp++;
                if (qa[n0 + i] !== exp) begin
                    n_bad++; $display("FAIL %s write%0d addr_data: got %h expected %h", tag, i, qa[n0 + i], exp);
                end
            end
        end
        n_cmp++;
        if (part_a !== 1'b0) begin n_bad++; $display("FAIL %s partial: got %b expected 0", tag, part_a); end
        n_cmp++;
        if (done_cyc_a != last_wr_a + 1) begin
            n_bad++; $display("FAIL %s done_latency: got %0d expected %0d", tag, done_cyc_a - last_wr_a, 1);
        end
        n_cmp++;
        if (busy_a !== 1'b0) begin n_bad++; $display("FAIL %s busy_after_done: got %b expected 0", tag, busy_a); end
        n_cmp++;
        if (idle_nz_a != i0) begin
            n_bad++; $display("FAIL %s idle_addr_data: got %0d nonzero cycles expected 0", tag, idle_nz_a - i0);
        end
    endtask

    task automatic test_passthrough();
        int e0, c0, d0;
        set_timing(32, 40, 8, 10);
        e0 = dly_err; c0 = dly_chk; d0 = done_cnt_a;
        x_a = 12'd10; y_a = 12'd5; start_a = 1'b1;
        step();
        start_a = 1'b0;
        repeat (800) step();
        n_cmp++;
        if (dly_err != e0) begin
            n_bad++; $display("FAIL passthrough_delay: got %0d bad cycles expected 0", dly_err - e0);
        end
        n_cmp++;
        if (dly_chk - c0 < 800) begin
            n_bad++; $display("FAIL passthrough_coverage: got %0d cycles expected >=800", dly_chk - c0);
        end
        n_cmp++;
        if (done_cnt_a - d0 != 1) begin
            n_bad++; $display("FAIL passthrough_done: got %0d pulses expected 1", done_cnt_a - d0);
        end
    endtask

    task automatic test_offscreen();
        int n0, d0;
        bit ok;
        logic [23:0] exp;
        set_timing(1024, 1032, 4, 6);
        n0 = qb.size(); d0 = done_cnt_b;
        x_b = 12'd1020; y_b = 12'd0; start_b = 1'b1;
        step();
        start_b = 1'b0;
        wait_done(1'b1, d0, 15000, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL edge_done_timeout: got none expected done"); end
        n_cmp++;
        if (qb.size() - n0 != 8) begin
            n_bad++; $display("FAIL edge_write_count: got %0d expected 8", qb.size() - n0);
        end
        for (int i = 0; i < 8; i++) begin
            if (n0 + i < qb.size()) begin
                exp = {12'((i / 4) * 64 + (i % 4)), pix(1020 + i % 4, i / 4)};
                n_cmp++;
                if (qb[n0 + i] !== exp) begin
                    n_bad++; $display("FAIL edge_write%0d addr_data: got %h expected %h", i, qb[n0 + i], exp);
                end
            end
        end
        n_cmp++;
        if (part_b !== 1'b1) begin n_bad++; $display("FAIL edge_partial: got %b expected 1", part_b); end
        n_cmp++;
        if (done_gap_b != 1) begin
            n_bad++; $display("FAIL edge_done_at_origin: got %0d cycles after origin expected 1", done_gap_b);
        end
    endtask

    task automatic test_restart_armed();
        int n0, d0;
        bit ok;
        logic [23:0] exp;
        set_timing(32, 40, 8, 10);
        n0 = qa.size(); d0 = done_cnt_a;
        x_a = 12'd10; y_a = 12'd5; start_a = 1'b1;
        step();
        start_a = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (busy_a !== 1'b1) begin n_bad++; $display("FAIL restart_armed_busy: got %b expected 1", busy_a); end
        x_a = 12'd0; y_a = 12'd0; start_a = 1'b1;
        step();
        start_a = 1'b0;
        wait_done(1'b0, d0, 1500, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL restart_done_timeout: got none expected done"); end
        repeat (900) step();
        n_cmp++;
        if (done_cnt_a - d0 != 1) begin
            n_bad++; $display("FAIL restart_done_pulses: got %0d expected 1", done_cnt_a - d0);
        end
        n_cmp++;
        if (qa.size() - n0 != 8) begin
            n_bad++; $display("FAIL restart_write_count: got %0d expected 8", qa.size() - n0);
        end
        for (int i = 0; i < 8; i++) begin
            if (n0 + i < qa.size()) begin
                exp = {12'((i / 4) * 64 + (i % 4)), pix(10 + i % 4, 5 + i / 4)};
                n_cmp++;
                if (qa[n0 + i] !== exp) begin
                    n_bad++; $display("FAIL restart_write%0d addr_data: got %h expected %h", i, qa[n0 + i], exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n0, d0, seen, k;
        set_timing(32, 40, 8, 10);
        n0 = qa.size(); d0 = done_cnt_a;
        x_a = 12'd10; y_a = 12'd5; start_a = 1'b1;
        step();
        start_a = 1'b0;
        seen = 0; k = 0;
        while (seen < 3 && k < 1500) begin
            step();
            k++;
            if (wr_en_a) seen++;
        end
        n_cmp++;
        if (seen < 3) begin n_bad++; $display("FAIL rstmid_third_write: got %0d writes expected 3", seen); end
        rst = 1'b1;
        step();
        n_cmp++;
        if ({busy_a, done_a, partial_a, wr_en_a, wr_addr_a, wr_data_a} !== 28'd0) begin
            n_bad++;
            $display("FAIL rstmid_outs: got %h expected 0",
                     {busy_a, done_a, partial_a, wr_en_a, wr_addr_a, wr_data_a});
        end
        n_cmp++;
        if ({vout_a.hcount, vout_a.vcount, vout_a.rgb} !== 36'd0) begin
            n_bad++; $display("FAIL rstmid_vga_out: got %h expected 0", {vout_a.hcount, vout_a.vcount, vout_a.rgb});
        end
        rst = 1'b0;
        repeat (900) step();
        n_cmp++;
        if (done_cnt_a != d0) begin
            n_bad++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", done_cnt_a - d0);
        end
        n_cmp++;
        if (qa.size() - n0 != 3) begin
            n_bad++; $display("FAIL rstmid_writes: got %0d expected 3", qa.size() - n0);
        end
    endtask

    task automatic test_hblank();
        int n0, d0;
        bit ok;
        set_timing(32, 40, 8, 10);
        n0 = qa.size(); d0 = done_cnt_a;
        x_a = 12'd34; y_a = 12'd5; start_a = 1'b1;
        step();
        start_a = 1'b0;
        wait_done(1'b0, d0, 1500, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL hblank_done_timeout: got none expected done"); end
        n_cmp++;
        if (qa.size() != n0) begin
            n_bad++; $display("FAIL hblank_writes: got %0d expected 0", qa.size() - n0);
        end
        n_cmp++;
        if (part_a !== 1'b1) begin n_bad++; $display("FAIL hblank_partial: got %b expected 1", part_a); end
        repeat (5) step();
        n_cmp++;
        if (partial_a !== 1'b1) begin n_bad++; $display("FAIL hblank_partial_hold: got %b expected 1", partial_a); end
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        x_a = '0; y_a = '0; x_b = '0; y_b = '0;
        set_timing(32, 40, 8, 10);
        test_reset();
        test_basic("basic");
        test_passthrough();
        test_offscreen();
        test_restart_armed();
        test_reset_mid();
        test_basic("after_rst");
        test_hblank();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
